// File: rtl/alarm_ctrl_pkg.sv
// Shared state encodings, BCD digit limits and reset time for the alarm controller.
// Also provides the wrap-around digit stepping helper used by the editor.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StRing  = 2'b10,
        StSnz   = 2'b11
    } alarm_state_e;

    localparam logic [3:0] MaxMin0    = 4'd9;
    localparam logic [3:0] MaxMin1    = 4'd5;
    localparam logic [3:0] MaxHr0     = 4'd9;
    localparam logic [3:0] MaxHr0At20 = 4'd3;
    localparam logic [3:0] MaxHr1     = 4'd2;

    localparam logic [15:0] AlarmRstVal = 16'h0600;

    localparam logic [1:0] SelMin0 = 2'd0;
    localparam logic [1:0] SelMin1 = 2'd1;
    localparam logic [1:0] SelHr0  = 2'd2;
    localparam logic [1:0] SelHr1  = 2'd3;

    // Step one BCD digit up or down, wrapping within 0..max_val.
    function automatic logic [3:0] step_digit(input logic [3:0] d,
                                              input logic [3:0] max_val,
                                              input logic       up);
        logic [3:0] r;
        if (up) begin
            r = (d >= max_val) ? 4'd0 : d + 4'd1;
        end else begin
            r = (d == 4'd0 || d > max_val) ? max_val : d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_digit_edit.sv
// Alarm time storage and set-mode editor: button edge detection, digit select
// rotation and per-digit BCD wrap with the 2x-hour clamp.
module alarm_digit_edit
    import alarm_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_i,
    input  logic [1:0]  set_ud_i,
    input  logic [1:0]  set_lr_i,
    output logic [15:0] value_o,
    output logic [3:0]  sel_o
);

    logic [3:0] min0_q, min0_d;
    logic [3:0] min1_q, min1_d;
    logic [3:0] hr0_q,  hr0_d;
    logic [3:0] hr1_q,  hr1_d;
    logic [1:0] sel_q,  sel_d;
    logic       up_q, dn_q, lt_q, rt_q;
    logic       up_e, dn_e, lt_e, rt_e;
    logic [3:0] hr0_max;
    logic [3:0] hr1_step;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min0_q <= AlarmRstVal[3:0];
            min1_q <= AlarmRstVal[7:4];
            hr0_q  <= AlarmRstVal[11:8];
            hr1_q  <= AlarmRstVal[15:12];
            sel_q  <= SelMin0;
            // Held buttons must not act right after reset.
            up_q   <= 1'b1;
            dn_q   <= 1'b1;
            lt_q   <= 1'b1;
            rt_q   <= 1'b1;
        end else begin
            min0_q <= min0_d;
            min1_q <= min1_d;
            hr0_q  <= hr0_d;
            hr1_q  <= hr1_d;
            sel_q  <= sel_d;
            up_q   <= set_ud_i[1];
            dn_q   <= set_ud_i[0];
            lt_q   <= set_lr_i[1];
            rt_q   <= set_lr_i[0];
        end
    end

    always_comb begin
        up_e     = set_ud_i[1] & ~up_q;
        dn_e     = set_ud_i[0] & ~dn_q;
        lt_e     = set_lr_i[1] & ~lt_q;
        rt_e     = set_lr_i[0] & ~rt_q;
        hr0_max  = (hr1_q == MaxHr1) ? MaxHr0At20 : MaxHr0;
        hr1_step = step_digit(hr1_q, MaxHr1, up_e);

        sel_d  = sel_q;
        min0_d = min0_q;
        min1_d = min1_q;
        hr0_d  = hr0_q;
        hr1_d  = hr1_q;

        if (set_i) begin
            if (lt_e && !rt_e) begin
                sel_d = sel_q + 2'd1;
            end else if (rt_e && !lt_e) begin
                sel_d = sel_q - 2'd1;
            end

            // Simultaneous up and down cancel out.
            if (up_e != dn_e) begin
                unique case (sel_q)
                    SelMin0: min0_d = step_digit(min0_q, MaxMin0, up_e);
                    SelMin1: min1_d = step_digit(min1_q, MaxMin1, up_e);
                    SelHr0:  hr0_d  = step_digit(hr0_q, hr0_max, up_e);
                    SelHr1: begin
                        hr1_d = hr1_step;
                        if (hr1_step == MaxHr1 && hr0_q > MaxHr0At20) begin
                            hr0_d = MaxHr0At20;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign value_o = {hr1_q, hr0_q, min1_q, min0_q};
    assign sel_o   = set_i ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: match edge detection against the BCD clock time and the
// IDLE/ARMED/RINGING/SNOOZE sequencer with minute-tick ring and snooze counters.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 1
) (
    input  logic        alarm_clk,
    input  logic        alarm_rst,
    input  logic        alarm_en,
    input  logic        alarm_set,
    input  logic [1:0]  alarm_set_ud,
    input  logic [1:0]  alarm_set_lr,
    input  logic        alarm_snooze,
    input  logic        alarm_stop,
    input  logic        alarm_min_tick,
    input  logic [15:0] alarm_time,
    output logic [15:0] alarm_value,
    output logic [3:0]  alarm_sel,
    output logic        alarm_ring,
    output logic [1:0]  alarm_state
);

    localparam logic [3:0] SnoozeLoad = 4'(SNOOZE_MIN);
    localparam logic [3:0] RingLoad   = 4'(RING_MIN);

    alarm_state_e state_q, state_d;
    logic [3:0]   ring_cnt_q, ring_cnt_d;
    logic [3:0]   snz_cnt_q, snz_cnt_d;
    logic         ring_q, ring_d;
    logic         match, match_q, trig;
    logic         snooze_q, stop_q;
    logic         snooze_e, stop_e;

    alarm_digit_edit u_digit_edit (
        .clk_i    (alarm_clk),
        .rst_i    (alarm_rst),
        .set_i    (alarm_set),
        .set_ud_i (alarm_set_ud),
        .set_lr_i (alarm_set_lr),
        .value_o  (alarm_value),
        .sel_o    (alarm_sel)
    );

    // Rising edge of the match so arming inside the alarm minute does not ring.
    assign match    = (alarm_time == alarm_value);
    assign trig     = match & ~match_q;
    assign snooze_e = alarm_snooze & ~snooze_q;
    assign stop_e   = alarm_stop & ~stop_q;

    always_ff @(posedge alarm_clk) begin
        if (alarm_rst) begin
            state_q    <= StIdle;
            ring_cnt_q <= 4'd0;
            snz_cnt_q  <= 4'd0;
            ring_q     <= 1'b0;
            match_q    <= 1'b0;
            snooze_q   <= 1'b1;
            stop_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_q     <= ring_d;
            match_q    <= match;
            snooze_q   <= alarm_snooze;
            stop_q     <= alarm_stop;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;

        if (alarm_set || !alarm_en) begin
            state_d    = StIdle;
            ring_cnt_d = 4'd0;
            snz_cnt_d  = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (trig) begin
                        state_d    = StRing;
                        ring_cnt_d = RingLoad;
                    end
                end
                StRing: begin
                    if (stop_e) begin
                        state_d    = StArmed;
                        ring_cnt_d = 4'd0;
                    end else if (snooze_e) begin
                        state_d    = StSnz;
                        ring_cnt_d = 4'd0;
                        snz_cnt_d  = SnoozeLoad;
                    end else if (alarm_min_tick) begin
                        if (ring_cnt_q <= 4'd1) begin
                            state_d    = StArmed;
                            ring_cnt_d = 4'd0;
                        end else begin
                            ring_cnt_d = ring_cnt_q - 4'd1;
                        end
                    end
                end
                StSnz: begin
                    if (stop_e) begin
                        state_d   = StArmed;
                        snz_cnt_d = 4'd0;
                    end else if (alarm_min_tick) begin
                        if (snz_cnt_q <= 4'd1) begin
                            state_d    = StRing;
                            snz_cnt_d  = 4'd0;
                            ring_cnt_d = RingLoad;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        ring_d = (state_d == StRing);
    end

    assign alarm_ring  = ring_q;
    assign alarm_state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: table-driven edit vectors followed by
// hand-written ring, snooze, re-arm and priority sequences.
module tb_alarm_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        set;
    logic [1:0]  set_ud;
    logic [1:0]  set_lr;
    logic        snooze;
    logic        stop;
    logic        tick;
    logic [15:0] time_bcd;
    logic [15:0] value;
    logic [3:0]  sel;
    logic        ring;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        set;
        logic [1:0]  ud;
        logic [1:0]  lr;
        logic        rel;
        logic [15:0] val;
        logic [3:0]  sel;
    } vec_t;

    vec_t vecs[$];

    alarm_ctrl #(
        .SNOOZE_MIN (5),
        .RING_MIN   (1)
    ) dut (
        .alarm_clk      (clk),
        .alarm_rst      (rst),
        .alarm_en       (en),
        .alarm_set      (set),
        .alarm_set_ud   (set_ud),
        .alarm_set_lr   (set_lr),
        .alarm_snooze   (snooze),
        .alarm_stop     (stop),
        .alarm_min_tick (tick),
        .alarm_time     (time_bcd),
        .alarm_value    (value),
        .alarm_sel      (sel),
        .alarm_ring     (ring),
        .alarm_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [1:0] ud, input logic [1:0] lr,
                       input logic rel, input logic [15:0] v, input logic [3:0] sl);
        vec_t x;
        x.set = s; x.ud = ud; x.lr = lr; x.rel = rel; x.val = v; x.sel = sl;
        vecs.push_back(x);
    endtask

    task automatic tap_ud(input logic [1:0] ud);
        set_ud = ud; step();
        set_ud = 2'b00; step();
    endtask

    task automatic tap_lr(input logic [1:0] lr);
        set_lr = lr; step();
        set_lr = 2'b00; step();
    endtask

    task automatic retrigger();
        time_bcd = 16'h0731; step();
        time_bcd = 16'h0730; step();
    endtask

    task automatic min_tick();
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; set = 1'b0; set_ud = 2'b00; set_lr = 2'b00;
        snooze = 1'b0; stop = 1'b0; tick = 1'b0; time_bcd = 16'h1200;
        step(); step();
        check("rst_value", value, 16'h0600);
        check("rst_sel", {12'h0, sel}, 16'h0000);
        check("rst_ring", {15'h0, ring}, 16'h0000);
        check("rst_state", {14'h0, state}, 16'h0000);
        rst = 1'b0;
        step();

        // set, ud, lr, release-after, expected value, expected sel
        add(1, 2'b00, 2'b00, 1, 16'h0600, 4'b0001);
        add(1, 2'b00, 2'b01, 1, 16'h0600, 4'b1000);
        add(1, 2'b10, 2'b00, 1, 16'h1600, 4'b1000);
        add(1, 2'b10, 2'b00, 1, 16'h2300, 4'b1000);
        add(1, 2'b10, 2'b00, 1, 16'h0300, 4'b1000);
        add(1, 2'b00, 2'b01, 1, 16'h0300, 4'b0100);
        add(1, 2'b10, 2'b00, 1, 16'h0400, 4'b0100);
        add(1, 2'b10, 2'b00, 1, 16'h0500, 4'b0100);
        add(1, 2'b10, 2'b00, 1, 16'h0600, 4'b0100);
        add(1, 2'b10, 2'b00, 1, 16'h0700, 4'b0100);
        add(1, 2'b00, 2'b10, 1, 16'h0700, 4'b1000);
        add(1, 2'b10, 2'b00, 1, 16'h1700, 4'b1000);
        add(1, 2'b10, 2'b00, 1, 16'h2300, 4'b1000);
        add(1, 2'b00, 2'b01, 1, 16'h2300, 4'b0100);
        add(1, 2'b10, 2'b00, 1, 16'h2000, 4'b0100);
        add(1, 2'b01, 2'b00, 1, 16'h2300, 4'b0100);
        add(1, 2'b00, 2'b01, 1, 16'h2300, 4'b0010);
        add(1, 2'b01, 2'b00, 1, 16'h2350, 4'b0010);
        add(1, 2'b11, 2'b00, 1, 16'h2350, 4'b0010);
        add(1, 2'b10, 2'b00, 1, 16'h2300, 4'b0010);
        add(1, 2'b00, 2'b01, 1, 16'h2300, 4'b0001);
        add(1, 2'b01, 2'b00, 1, 16'h2309, 4'b0001);
        add(1, 2'b10, 2'b00, 1, 16'h2300, 4'b0001);
        add(1, 2'b00, 2'b01, 1, 16'h2300, 4'b1000);
        add(0, 2'b10, 2'b00, 0, 16'h2300, 4'b0000);
        add(1, 2'b10, 2'b00, 1, 16'h2300, 4'b1000);

        foreach (vecs[i]) begin
            set = vecs[i].set; set_ud = vecs[i].ud; set_lr = vecs[i].lr;
            step();
            check($sformatf("edit%0d_value", i), value, vecs[i].val);
            check($sformatf("edit%0d_sel", i), {12'h0, sel}, {12'h0, vecs[i].sel});
            if (vecs[i].rel) begin
                set_ud = 2'b00; set_lr = 2'b00;
                step();
                check($sformatf("edit%0d_hold", i), value, vecs[i].val);
            end
        end
        set = 1'b0; set_ud = 2'b00; set_lr = 2'b00;

        // Fresh alarm at 07:30 from the reset value.
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
        check("rst2_value", value, 16'h0600);
        set = 1'b1; step();
        tap_lr(2'b10);
        for (int k = 0; k < 3; k++) tap_ud(2'b10);
        tap_lr(2'b10);
        tap_ud(2'b10);
        set = 1'b0; step();
        check("set_0730", value, 16'h0730);

        time_bcd = 16'h0729; en = 1'b1; step();
        check("armed", {14'h0, state}, 16'h0001);
        time_bcd = 16'h0730; step();
        check("ring_on", {15'h0, ring}, 16'h0001);
        check("ring_state", {14'h0, state}, 16'h0002);
        tick = 1'b1; step(); tick = 1'b0;
        check("ring_timeout", {15'h0, ring}, 16'h0000);
        check("timeout_state", {14'h0, state}, 16'h0001);
        step(); step(); step();
        check("no_retrig", {15'h0, ring}, 16'h0000);

        retrigger();
        check("ring2", {15'h0, ring}, 16'h0001);
        snooze = 1'b1; step();
        check("snz_state", {14'h0, state}, 16'h0003);
        check("snz_ring", {15'h0, ring}, 16'h0000);
        snooze = 1'b0; step();
        snooze = 1'b1; step(); snooze = 1'b0; step();
        check("snz_ignored", {14'h0, state}, 16'h0003);
        for (int k = 0; k < 4; k++) min_tick();
        check("snz_4ticks", {14'h0, state}, 16'h0003);
        tick = 1'b1; step(); tick = 1'b0;
        check("snz_reting", {15'h0, ring}, 16'h0001);
        check("snz_reting_state", {14'h0, state}, 16'h0002);
        stop = 1'b1; step();
        check("stop_state", {14'h0, state}, 16'h0001);
        check("stop_ring", {15'h0, ring}, 16'h0000);
        stop = 1'b0; step();

        // Re-arm while the time already matches.
        en = 1'b0; step();
        check("disarm", {14'h0, state}, 16'h0000);
        en = 1'b1; step();
        check("rearm", {14'h0, state}, 16'h0001);
        step(); step(); step();
        check("rearm_noring", {15'h0, ring}, 16'h0000);
        retrigger();
        check("nextday_ring", {15'h0, ring}, 16'h0001);

        stop = 1'b1; snooze = 1'b1; step();
        check("stop_over_snz", {14'h0, state}, 16'h0001);
        stop = 1'b0; snooze = 1'b0; step();
        retrigger();
        snooze = 1'b1; step();
        check("snz_again", {14'h0, state}, 16'h0003);
        en = 1'b0; step();
        check("en_off_snz", {14'h0, state}, 16'h0000);
        check("en_off_ring", {15'h0, ring}, 16'h0000);
        snooze = 1'b0; en = 1'b1; step();
        retrigger();
        check("ring_before_rst", {14'h0, state}, 16'h0002);
        rst = 1'b1; step();
        check("rst_mid_state", {14'h0, state}, 16'h0000);
        check("rst_mid_ring", {15'h0, ring}, 16'h0000);
        check("rst_mid_value", value, 16'h0600);
        rst = 1'b0; step();
        check("post_rst_armed", {14'h0, state}, 16'h0001);
        check("post_rst_ring", {15'h0, ring}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
